// File: rtl/ooop_types_pkg.sv
// ooop_types: shared decode packet, functional-unit and branch-state types.
package ooop_types;
    typedef enum logic [1:0] {FU_ALU = 2'd0, FU_LSU = 2'd1, FU_BRU = 2'd2} fu_t;
    typedef struct packed {
        fu_t         fu_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } decode_pkt_t;
    typedef enum logic {BR_IDLE, BR_PEND} br_state_t;
    localparam int SEQ_W = 6;
endpackage

// File: rtl/dispatch_buf.sv
// dispatch_buf: DEPTH-entry in-order packet FIFO; flush empties it in one cycle.
module dispatch_buf
    import ooop_types::*;
#(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_i,
    input  logic          pop_i,
    input  decode_pkt_t   din_i,
    output decode_pkt_t   head_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    decode_pkt_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : AW'(p + 1);
    endfunction
    // storage is reset too so the head reads as zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= inc(wr_q);
            end
            if (pop_i) rd_q <= inc(rd_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: routes buffered decode packets to ALU/LSU/BRU with one-branch-in-flight blocking.
// Optional DISPATCH_STATS_EN adds dispatch and stall counters.
module dispatch_ctrl
    import ooop_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             bru_resolve_in,
    input  logic             dec_valid_in,
    output logic             dec_ready_out,
    input  decode_pkt_t      dec_pkt_in,
    input  logic             alu_ready_in,
    input  logic             lsu_ready_in,
    input  logic             bru_ready_in,
    input  logic             rob_ready_in,
    output logic             alu_valid_out,
    output logic             lsu_valid_out,
    output logic             bru_valid_out,
    output decode_pkt_t      pkt_out,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]      stat_dispatched,
    output logic [31:0]      stat_stall,
`endif
    output logic [SEQ_W-1:0] seq_out
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0]    count;
    decode_pkt_t      head;
    br_state_t        br_q, br_d;
    logic [SEQ_W-1:0] seq_q;
    logic             push, fire, live, is_bru, is_lsu;
    dispatch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk(clk), .rst(rst), .flush(flush), .push_i(push), .pop_i(fire),
        .din_i(dec_pkt_in), .head_o(head), .count_o(count)
    );
    assign dec_ready_out = !rst && !flush && (count < CW'(DEPTH));
    assign push          = dec_valid_in && dec_ready_out;
    assign live          = !flush && rob_ready_in && (count != '0);
    assign is_bru        = head.fu_type == FU_BRU;
    assign is_lsu        = head.fu_type == FU_LSU;
    always_comb begin
        alu_valid_out = live && !is_bru && !is_lsu;
        lsu_valid_out = live && is_lsu;
        bru_valid_out = live && is_bru && (br_q == BR_IDLE);
        fire = (alu_valid_out && alu_ready_in) || (lsu_valid_out && lsu_ready_in) ||
               (bru_valid_out && bru_ready_in);
        br_d = (bru_valid_out && bru_ready_in) ? BR_PEND :
               (bru_resolve_in || flush) ? BR_IDLE : br_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q  <= BR_IDLE;
            seq_q <= '0;
        end else begin
            br_q <= br_d;
            if (fire) seq_q <= seq_q + 1'b1;
        end
    end
    assign pkt_out = head;
    assign seq_out = seq_q;
`ifdef DISPATCH_STATS_EN
    logic [31:0] disp_q, stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= '0;
            stall_q <= '0;
        end else begin
            if (fire) disp_q <= disp_q + 1;
            if (count != '0 && !fire) stall_q <= stall_q + 1;
        end
    end
    assign stat_dispatched = disp_q;
    assign stat_stall      = stall_q;
`endif
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed + random checks of dispatch_ctrl against a queue-based reference model.
module tb_dispatch_ctrl;
    import ooop_types::*;
    localparam int DEPTH = 2;
    logic clk = 0, rst, flush, bru_resolve_in, dec_valid_in, dec_ready_out;
    logic alu_ready_in, lsu_ready_in, bru_ready_in, rob_ready_in;
    logic alu_valid_out, lsu_valid_out, bru_valid_out;
    decode_pkt_t dec_pkt_in, pkt_out, saved;
    logic [SEQ_W-1:0] seq_out;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_dispatched, stat_stall;
`endif
    always #5 clk = ~clk;
    dispatch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bru_resolve_in(bru_resolve_in),
        .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out), .dec_pkt_in(dec_pkt_in),
        .alu_ready_in(alu_ready_in), .lsu_ready_in(lsu_ready_in), .bru_ready_in(bru_ready_in),
        .rob_ready_in(rob_ready_in), .alu_valid_out(alu_valid_out), .lsu_valid_out(lsu_valid_out),
        .bru_valid_out(bru_valid_out), .pkt_out(pkt_out),
`ifdef DISPATCH_STATS_EN
        .stat_dispatched(stat_dispatched), .stat_stall(stat_stall),
`endif
        .seq_out(seq_out)
    );
    int checks = 0, errors = 0;
    decode_pkt_t q[$];
    int m_seq, m_disp, m_stall, saved_seq, n, s0;
    bit m_pend, acc;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic decode_pkt_t make_pkt(input int fu);
        decode_pkt_t p;
        p.fu_type = fu_t'(2'(fu));
        p.rd  = 5'($urandom);
        p.rs1 = 5'($urandom);
        p.rs2 = 5'($urandom);
        p.imm = 16'($urandom);
        return p;
    endfunction
    task automatic model_reset();
        q.delete();
        m_seq = 0; m_pend = 0; m_disp = 0; m_stall = 0;
    endtask
    // one cycle: compare DUT against the model, then advance the model across the edge
    task automatic step();
        bit rdy, pres, av, lv, bv, fire, fire_b, stall;
        int eff;
        #1;
        rdy   = (q.size() < DEPTH) && !flush;
        pres  = (q.size() > 0) && !flush && rob_ready_in;
        eff   = pres ? ((q[0].fu_type == FU_BRU) ? 2 : (q[0].fu_type == FU_LSU) ? 1 : 0) : 0;
        av    = pres && eff == 0;
        lv    = pres && eff == 1;
        bv    = pres && eff == 2 && !m_pend;
        fire_b = bv && bru_ready_in;
        fire  = (av && alu_ready_in) || (lv && lsu_ready_in) || fire_b;
        stall = (q.size() > 0) && !fire;
        chk("dec_ready", 64'(dec_ready_out), 64'(rdy));
        chk("alu_valid", 64'(alu_valid_out), 64'(av));
        chk("lsu_valid", 64'(lsu_valid_out), 64'(lv));
        chk("bru_valid", 64'(bru_valid_out), 64'(bv));
        chk("seq", 64'(seq_out), 64'(m_seq));
        if (av || lv || bv) chk("pkt", 64'(pkt_out), 64'(q[0]));
`ifdef DISPATCH_STATS_EN
        chk("stat_disp", 64'(stat_dispatched), 64'(32'(m_disp)));
        chk("stat_stall", 64'(stat_stall), 64'(32'(m_stall)));
`endif
        acc = dec_valid_in && rdy;
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_pend = 0;
        end else begin
            if (fire) begin
                void'(q.pop_front());
                m_seq = (m_seq + 1) % 64;
            end
            if (acc) q.push_back(dec_pkt_in);
            m_pend = fire_b ? 1 : bru_resolve_in ? 0 : m_pend;
        end
        m_disp  += int'(fire);
        m_stall += int'(stall);
        @(negedge clk);
    endtask
    task automatic push_hold(input int fu);
        dec_pkt_in = make_pkt(fu);
        dec_valid_in = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (acc) break;
        end
        dec_valid_in = 0;
    endtask
    initial begin
        rst = 1; flush = 0; bru_resolve_in = 0; dec_valid_in = 0; dec_pkt_in = '0;
        alu_ready_in = 0; lsu_ready_in = 0; bru_ready_in = 0; rob_ready_in = 0;
        model_reset();
        #1;
        chk("rst_ready", 64'(dec_ready_out), 64'(0));
        chk("rst_valids", 64'({alu_valid_out, lsu_valid_out, bru_valid_out}), 64'(0));
        chk("rst_seq", 64'(seq_out), 64'(0));
        chk("rst_pkt", 64'(pkt_out), 64'(0));
        @(negedge clk); @(negedge clk);
        rst = 0;
        // single ALU packet, one-cycle latency
        alu_ready_in = 1; lsu_ready_in = 1; bru_ready_in = 1; rob_ready_in = 1;
        dec_valid_in = 1; dec_pkt_in = make_pkt(0);
        step();
        dec_valid_in = 0;
        chk("t25_valid", 64'(alu_valid_out), 64'(1));
        chk("t25_seq0", 64'(seq_out), 64'(0));
        step();
        chk("t25_seq1", 64'(seq_out), 64'(1));
        // backpressure fills the buffer, then in-order drain
        alu_ready_in = 0;
        dec_valid_in = 1;
        dec_pkt_in = make_pkt(0); step();
        dec_pkt_in = make_pkt(3); step();
        dec_pkt_in = make_pkt(0); step();
        chk("t26_full", 64'(dec_ready_out), 64'(0));
        alu_ready_in = 1;
        for (int k = 0; k < 2; k++) step();
        dec_valid_in = 0;
        for (int k = 0; k < 2; k++) step();
        chk("t26_seq", 64'(seq_out), 64'(4));
        // second branch waits for resolve
        push_hold(2); push_hold(2); push_hold(0);
        for (int k = 0; k < 3; k++) step();
        chk("t27_block", 64'(bru_valid_out), 64'(0));
        bru_resolve_in = 1; step(); bru_resolve_in = 0;
        chk("t27_unblock", 64'(bru_valid_out), 64'(1));
        step();
        // full buffer with a pending branch, then flush
        alu_ready_in = 0;
        n = 0;
        while (q.size() < DEPTH && n < 10) begin push_hold(0); n++; end
        chk("t28_full", 64'(dec_ready_out), 64'(0));
        saved_seq = int'(seq_out);
        flush = 1; dec_valid_in = 1; dec_pkt_in = make_pkt(1);
        step();
        flush = 0; dec_valid_in = 0; alu_ready_in = 1;
        chk("t28_valids", 64'({alu_valid_out, lsu_valid_out, bru_valid_out}), 64'(0));
        chk("t28_seq", 64'(seq_out), 64'(saved_seq));
        dec_valid_in = 1; dec_pkt_in = make_pkt(2); step(); dec_valid_in = 0;
        chk("t28_idle", 64'(bru_valid_out), 64'(1));
        step();
        // ROB stall with LSU head
        rob_ready_in = 0;
        dec_valid_in = 1; dec_pkt_in = make_pkt(1); step(); dec_valid_in = 0;
        saved = pkt_out;
`ifdef DISPATCH_STATS_EN
        s0 = int'(stat_stall);
`endif
        for (int k = 0; k < 5; k++) begin
            chk("t29_lsu", 64'(lsu_valid_out), 64'(0));
            chk("t29_pkt", 64'(pkt_out), 64'(saved));
            step();
        end
`ifdef DISPATCH_STATS_EN
        chk("t29_stall", 64'(stat_stall), 64'(32'(s0 + 5)));
`endif
        rob_ready_in = 1; step();
        // random traffic
        for (int k = 0; k < 400; k++) begin
            flush = ($urandom % 20) == 0;
            bru_resolve_in = ($urandom % 6) == 0;
            dec_valid_in = ($urandom % 4) != 0;
            alu_ready_in = ($urandom % 4) != 0;
            lsu_ready_in = ($urandom % 4) != 0;
            bru_ready_in = ($urandom % 4) != 0;
            rob_ready_in = ($urandom % 5) != 0;
            dec_pkt_in = make_pkt(int'($urandom_range(0, 3)));
            step();
        end
        // sequence wrap
        flush = 0; bru_resolve_in = 0; dec_valid_in = 1;
        alu_ready_in = 1; lsu_ready_in = 1; bru_ready_in = 1; rob_ready_in = 1;
        s0 = m_disp;
        for (int k = 0; k < 300; k++) begin
            dec_pkt_in = make_pkt(0);
            step();
            if (m_seq == 0 && m_disp > s0) break;
        end
        chk("t30_wrap", 64'(seq_out), 64'(0));
        // asynchronous reset mid-dispatch
        step();
        chk("t30_active", 64'(alu_valid_out), 64'(1));
        #2 rst = 1;
        #1;
        chk("t30_ready", 64'(dec_ready_out), 64'(0));
        chk("t30_valids", 64'({alu_valid_out, lsu_valid_out, bru_valid_out}), 64'(0));
        chk("t30_seq", 64'(seq_out), 64'(0));
        chk("t30_pkt", 64'(pkt_out), 64'(0));
`ifdef DISPATCH_STATS_EN
        chk("t30_stats", 64'({stat_dispatched, stat_stall}), 64'(0));
`endif
        @(negedge clk);
        rst = 0; dec_valid_in = 0;
        model_reset();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: flush in 1 (mispredict squash); bru_resolve_in in 1 (oldest branch resolved, one-cycle pulse).
REQ-004 SHALL have ports: dec_valid_in in 1; dec_ready_out out 1; dec_pkt_in in decode_pkt_t.
REQ-005 SHALL have ports: alu_ready_in, lsu_ready_in, bru_ready_in, rob_ready_in in 1 each; alu_valid_out, lsu_valid_out, bru_valid_out out 1 each.
REQ-006 SHALL have ports: pkt_out out decode_pkt_t (shared by all FUs); seq_out out 6 (dispatch sequence tag).
REQ-007 SHALL have parameter: DEPTH, default 2, buffer entries, legal 2..8.

Function
REQ-008 SHALL buffer decode packets in a DEPTH-entry in-order FIFO; dec_ready_out = (count < DEPTH) && !flush, independent of same-cycle dequeue.
REQ-009 SHALL enqueue when dec_valid_in && dec_ready_out; the packet becomes dispatchable the next cycle (1-cycle minimum latency).
REQ-010 SHALL route the FIFO head by fu_type: FU_ALU->alu, FU_LSU->lsu, FU_BRU->bru; exactly one *_valid_out high when the head is dispatchable, others 0.
REQ-011 SHALL dispatch the head when the selected FU ready && rob_ready_in && !flush && !branch block; *_valid_out SHALL NOT depend on the FU's own ready.
REQ-012 SHALL keep pkt_out and seq_out stable while *_valid_out is high and not accepted.
REQ-013 SHALL support simultaneous enqueue and dequeue; count unchanged, pointers each advance, wrapping mod DEPTH.
REQ-014 SHALL implement branch FSM states BR_IDLE, BR_PEND: BR_IDLE->BR_PEND on BRU dispatch; BR_PEND->BR_IDLE on bru_resolve_in or flush.
REQ-015 SHALL block (drive bru_valid_out 0) a BRU head while in BR_PEND; ALU/LSU heads are unaffected; bru_resolve_in in the same cycle as a BRU dispatch SHALL leave BR_PEND (dispatch wins).
REQ-016 SHALL increment seq_out by 1 (mod 64) on every dispatch; seq_out is the tag of the current head.
REQ-017 SHALL on flush: empty the FIFO, drop any same-cycle enqueue, drive all *_valid_out 0, force BR_IDLE, hold seq_out value.
REQ-018 SHALL treat a packet with fu_type outside the three enums as FU_ALU.

Reset
REQ-019 SHALL on rst: count 0, pointers 0, BR_IDLE, seq_out 0, all *_valid_out 0, dec_ready_out 0 while rst asserted, pkt_out '0.
REQ-020 SHALL abandon any in-flight handshake when rst asserts mid-operation; no dispatch in a reset cycle.

Configuration
REQ-021 SHALL, with DISPATCH_STATS_EN defined, add outputs stat_dispatched (32, +1 per dispatch) and stat_stall (32, +1 per cycle with non-empty FIFO and no dispatch), both wrapping, both reset to 0 by rst only (not flush).
REQ-022 SHALL, without DISPATCH_STATS_EN, omit those ports and counters entirely; other behaviour identical.

Structure
REQ-023 SHALL take decode_pkt_t and fu_t from ooop_types; SHALL add to ooop_types a br_state_t enum (BR_IDLE, BR_PEND) and localparam SEQ_W = 6.
REQ-024 SHALL place FIFO storage and pointers in sub-module dispatch_buf; routing, branch FSM, sequence counter and stats stay in dispatch_ctrl.

Verification
REQ-025 SHALL cover: reset, then ALU pkt enqueued, all readies 1 -> alu_valid_out 1 next cycle, seq_out 0, then 1 after accept.
REQ-026 SHALL cover: DEPTH=2, three back-to-back pkts, alu_ready_in 0 -> dec_ready_out 0 after 2 enqueues; raise ready -> in-order dispatch, seq 0,1,2.
REQ-027 SHALL cover: BRU, BRU, ALU queued, no resolve -> first BRU dispatched, second blocked (bru_valid_out 0) until bru_resolve_in pulse, then dispatched next cycle.
REQ-028 SHALL cover: FIFO full plus BR_PEND, flush pulse with dec_valid_in 1 -> next cycle count 0, all valids 0, BR_IDLE, seq_out unchanged.
REQ-029 SHALL cover: rob_ready_in 0 for 5 cycles with LSU head -> lsu_valid_out 0, pkt_out stable; with DISPATCH_STATS_EN stat_stall = 5.
REQ-030 SHALL cover: 64 dispatches from seq_out 0 -> seq_out wraps to 0; rst asserted mid-dispatch -> all outputs at reset values asynchronously.
